hls_call_initiator: RTL and testbench
=====================================

HLS_CALL_INITIATOR -- requirements
Module: hls_call_initiator

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width.
REQ-002 Parameter: TIMEOUT, 16, maximum cycles from fu_req to fu_ack before abort (range 2..255).
REQ-003 Parameter: DEPTH, 2, operand queue entries (power of two).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  operand pair offered.
REQ-007 in_ready  out  1  queue can accept; transfer when in_valid & in_ready.
REQ-008 in_a, in_b  in  WIDTH  operands.
REQ-009 fu_req  out  1  call request to the functional unit (req/ack FSM wrapper).
REQ-010 fu_ack  in  1  single-cycle completion pulse from the functional unit.
REQ-011 fu_p0, fu_p1  out  WIDTH  operands to the functional unit.
REQ-012 fu_out  in  WIDTH  functional-unit result, valid in the fu_ack cycle.
REQ-013 out_valid  out  1  result held for the consumer.
REQ-014 out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
REQ-015 out_data  out  WIDTH  result.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 timeout_err  out  1  sticky abort flag.

Function
REQ-018 Operand queue: DEPTH-entry FIFO; in_ready = not full; a push and a pop in the same cycle on a full queue SHALL accept both.
REQ-019 FSM states: IDLE, CALL, WAIT.
REQ-020 IDLE->CALL when the queue is non-empty and out_valid=0, or out_valid & out_ready in that same cycle.
REQ-021 CALL: fu_req=1 for exactly one cycle; unconditional move to WAIT; wait counter cleared to 0.
REQ-022 fu_p0/fu_p1 SHALL equal the queue head from the CALL cycle until the cycle after fu_ack or abort, with no change in between.
REQ-023 WAIT: counter increments each cycle; on fu_ack, capture fu_out into out_data, set out_valid, pop the queue, and go to IDLE.
REQ-024 WAIT abort: when the counter reaches TIMEOUT-1 with no fu_ack, set timeout_err, pop the queue (entry dropped), leave out_valid unchanged, and go to IDLE.
REQ-025 fu_ack and the timeout on the same cycle: ack wins, with no error.
REQ-026 fu_ack in IDLE or CALL SHALL be ignored, with no state or output change.
REQ-027 out_valid stays high and out_data stays stable until out_ready; out_valid clears on transfer unless a new capture occurs that cycle.
REQ-028 Latency: operand pushed in cycle t -> fu_req in t+1 (queue empty, output free); FU acking N cycles after req -> out_valid in t+1+N+1.
REQ-029 Throughput: back-to-back calls SHALL issue fu_req in the cycle after return to IDLE (minimum 1 idle cycle between calls).
REQ-030 timeout_err clears only on reset.

Reset
REQ-031 During reset and in the following cycle: state=IDLE, queue empty, fu_req=0, out_valid=0, out_data=0, fu_p0=fu_p1=0, busy=0, timeout_err=0, counter=0, in_ready=1 after release.
REQ-032 Reset asserted mid-call SHALL abandon the call; a later fu_ack SHALL be ignored per REQ-026.

Structure
REQ-033 Package hls_call_pkg holds the FSM state enum and the default WIDTH/TIMEOUT/DEPTH constants.
REQ-034 The queue SHALL be one sub-module, hls_call_fifo (parameters WIDTH*2, DEPTH; push/pop/full/empty/head).
REQ-035 The counter width SHALL be $clog2(TIMEOUT)+1.

Verification
REQ-036 Single call, FU model acking 3 cycles after req returning a*b: push (2.0, 3.0) -> one fu_req pulse; out_valid after 5 cycles; out_data=0x40C00000.
REQ-037 Push 3 pairs back-to-back with out_ready=1 -> in_ready low on the 3rd push until the first pop; 3 results returned in order; exactly 3 fu_req pulses.
REQ-038 Consumer stall: out_ready=0 for 10 cycles with 2 queued -> no second fu_req until out_ready=1; out_data stable throughout.
REQ-039 FU never acks, TIMEOUT=16 -> timeout_err=1 exactly 16 cycles after fu_req; entry dropped; next entry issued normally.
REQ-040 Spurious fu_ack while IDLE, then reset asserted during WAIT followed by a late fu_ack -> no out_valid; all outputs at reset values.

Source files
------------

// File: rtl/hls_call_pkg.sv
// Shared constants and FSM state encoding for the HLS call initiator.
package hls_call_pkg;
  localparam int HC_WIDTH   = 32;
  localparam int HC_TIMEOUT = 16;
  localparam int HC_DEPTH   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALL = 2'd1,
    ST_WAIT = 2'd2
  } call_state_e;
endpackage

// File: rtl/hls_call_fifo.sv
// Operand queue: DEPTH-entry FIFO (DEPTH a power of two, >= 2) with head peek.
module hls_call_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  // A push on a full queue is legal when a pop frees the slot in the same cycle.
  assign w_push  = i_push & (~o_full | i_pop);
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/hls_call_initiator.sv
// Queues operand pairs, issues one req/ack call per entry to a functional unit,
// holds the result for the consumer and aborts calls that exceed TIMEOUT.
module hls_call_initiator
  import hls_call_pkg::*;
#(
  parameter int WIDTH   = HC_WIDTH,
  parameter int TIMEOUT = HC_TIMEOUT,
  parameter int DEPTH   = HC_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  output logic             o_fu_req,
  input  logic             i_fu_ack,
  output logic [WIDTH-1:0] o_fu_p0,
  output logic [WIDTH-1:0] o_fu_p1,
  input  logic [WIDTH-1:0] i_fu_out,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_busy,
  output logic             o_timeout_err
);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CALL = ST_CALL;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam int         CW     = $clog2(TIMEOUT) + 1;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_p0, r_p1, r_out_data;
  logic               r_out_valid, r_tmo_err;

  logic [2*WIDTH-1:0] w_head, w_head_src;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_full, w_empty, w_push, w_pop, w_ack, w_tmo, w_start;

  hls_call_fifo #(.WIDTH(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  ({i_in_a, i_in_b}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_push     = i_in_valid & o_in_ready;
  assign w_ack      = (r_state == S_WAIT) & i_fu_ack;
  assign w_cnt_nxt  = r_cnt + CW'(1);
  // Abort when the count steps onto TIMEOUT-1; an ack in that cycle wins.
  assign w_tmo      = (r_state == S_WAIT) & ~i_fu_ack & (w_cnt_nxt == CW'(TIMEOUT-1));
  assign w_pop      = w_ack | w_tmo;
  assign o_in_ready = ~w_full | w_pop;

  // An operand arriving into an empty queue can launch immediately.
  assign w_start    = (r_state == S_IDLE) & (~w_empty | w_push) &
                      (~r_out_valid | i_out_ready);
  assign w_head_src = w_empty ? {i_in_a, i_in_b} : w_head;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_p0        <= '0;
      r_p1        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_state      <= S_CALL;
          {r_p0, r_p1} <= w_head_src;
        end
        S_CALL: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end
        S_WAIT: begin
          r_cnt <= w_cnt_nxt;
          if (w_pop) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_ack) begin
        r_out_data  <= i_fu_out;
        r_out_valid <= 1'b1;
      end else if (r_out_valid & i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_tmo) r_tmo_err <= 1'b1;
    end
  end

  assign o_fu_req      = (r_state == S_CALL);
  assign o_busy        = (r_state != S_IDLE);
  assign o_fu_p0       = r_p0;
  assign o_fu_p1       = r_p1;
  assign o_out_valid   = r_out_valid;
  assign o_out_data    = r_out_data;
  assign o_timeout_err = r_tmo_err;
endmodule

// File: tb/tb_hls_call_initiator.sv
// Scoreboard bench: FU model with per-entry ack delay, randomized operands and consumer.
module tb_hls_call_initiator;
  localparam int W   = 32;
  localparam int TMO = 16;
  localparam int DEP = 2;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, fu_ack, out_ready;
  logic [W-1:0] in_a = '0, in_b = '0, fu_out;
  logic         in_ready, fu_req, out_valid, busy, tmo_err;
  logic [W-1:0] fu_p0, fu_p1, out_data;

  hls_call_initiator #(.WIDTH(W), .TIMEOUT(TMO), .DEPTH(DEP)) dut (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_a(in_a), .i_in_b(in_b), .o_fu_req(fu_req), .i_fu_ack(fu_ack),
    .o_fu_p0(fu_p0), .o_fu_p1(fu_p1), .i_fu_out(fu_out), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_data(out_data), .o_busy(busy), .o_timeout_err(tmo_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  logic [63:0] op_q[$];
  int          dly_q[$];
  logic [31:0] exp_q[$];
  int          req_cyc[$], ack_cyc[$];
  bit fu_auto = 1'b1, man_ack = 1'b0, rnd_ready = 1'b0, ready_man = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++; bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // FP32 multiply for normal operands, truncating the mantissa.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic [22:0] f;
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (m[47]) begin e = e + 10'd1; f = m[46:24]; end
    else f = m[45:23];
    return {a[31] ^ b[31], e[7:0], f};
  endfunction

  function automatic logic [31:0] rnd_f();
    return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // Functional-unit model: acks N cycles after fu_req (N=0: never), returns a*b.
  initial begin
    int n = 0, k = 0;
    bit act = 1'b0, prev_req = 1'b0;
    logic [63:0] ops;
    fu_ack = 1'b0; fu_out = '0;
    forever begin
      @(posedge clk); #1;
      fu_ack = 1'b0;
      if (act) begin
        k++;
        if (k == n) begin
          fu_ack = 1'b1; fu_out = fmul(fu_p0, fu_p1); act = 1'b0;
          ack_cyc.push_back(cyc);
        end
      end
      if (!fu_auto) fu_ack = man_ack;
      if (fu_req) begin
        req_cyc.push_back(cyc);
        chk("fu_req_one_cycle", 64'(prev_req), 0);
        if (op_q.size() == 0) fail_now("fu_req_without_operand");
        else begin
          ops = op_q.pop_front();
          chk("fu_p0", 64'(fu_p0), 64'(ops[63:32]));
          chk("fu_p1", 64'(fu_p1), 64'(ops[31:0]));
          n = dly_q.pop_front(); k = 0;
          act = (n > 0) && fu_auto;
        end
      end
      prev_req = fu_req;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_man;
    end
  end

  // Output monitor: in-order results and hold-while-stalled.
  initial begin
    logic [31:0] held = '0;
    bit stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin stall = 1'b0; continue; end
      if (stall) begin
        chk("out_valid_hold", 64'(out_valid), 1);
        chk("out_data_hold", 64'(out_data), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_out_valid");
        else chk("result", 64'(out_data), 64'(exp_q.pop_front()));
        stall = 1'b0;
      end else if (out_valid) begin
        stall = 1'b1; held = out_data;
      end else stall = 1'b0;
    end
  end

  // Called right after a posedge; returns the cycle the transfer happened in.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input int n, output int acc);
    in_valid = 1'b1; in_a = a; in_b = b; acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        op_q.push_back({a, b}); dly_q.push_back(n);
        if (n > 0) exp_q.push_back(fmul(a, b));
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (acc < 0) fail_now("push_never_accepted");
  endtask

  task automatic wait_idle(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && op_q.size() == 0 && !busy && !out_valid) begin
        done = 1'b1; break;
      end
    end
    if (!done) fail_now(nm);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_fu_req"}, 64'(fu_req), 0);
    chk({nm, "_out_valid"}, 64'(out_valid), 0);
    chk({nm, "_out_data"}, 64'(out_data), 0);
    chk({nm, "_busy"}, 64'(busy), 0);
    chk({nm, "_tmo_err"}, 64'(tmo_err), 0);
    chk({nm, "_fu_p"}, {fu_p0, fu_p1}, 0);
  endtask

  initial begin
    int t, a1, a2, a3, tv, n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 1);
    chk_reset_vals("post_reset");
    @(posedge clk); #1;

    // Single call, ack 3 cycles after req.
    req_cyc.delete();
    push(32'h40000000, 32'h40400000, 3, t);
    tv = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin tv = cyc; break; end
    end
    chk("c1_out_latency", 64'(tv), 64'(t + 5));
    chk("c1_out_data", 64'(out_data), 64'h40C00000);
    chk("c1_req_count", 64'(req_cyc.size()), 1);
    if (req_cyc.size() > 0) chk("c1_req_latency", 64'(req_cyc[0]), 64'(t + 1));
    @(posedge clk); #1;
    wait_idle("c1_drain_timeout");

    // Three back-to-back pushes into a 2-entry queue.
    req_cyc.delete(); ack_cyc.delete();
    push(rnd_f(), rnd_f(), 3, a1);
    push(rnd_f(), rnd_f(), 3, a2);
    push(rnd_f(), rnd_f(), 3, a3);
    chk("bb_second_push", 64'(a2), 64'(a1 + 1));
    chk("bb_third_push_waits_pop", 64'(a3), 64'(a1 + 4));
    wait_idle("bb_drain_timeout");
    chk("bb_req_count", 64'(req_cyc.size()), 3);
    if (req_cyc.size() > 1 && ack_cyc.size() > 0)
      chk("bb_reissue_gap", 64'(req_cyc[1]), 64'(ack_cyc[0] + 2));

    // Consumer stall holds off the second call.
    ready_man = 1'b0;
    @(posedge clk); #1;
    req_cyc.delete();
    push(rnd_f(), rnd_f(), 2, t);
    push(rnd_f(), rnd_f(), 2, t);
    repeat (12) @(negedge clk);
    chk("stall_out_valid", 64'(out_valid), 1);
    chk("stall_no_second_req", 64'(req_cyc.size()), 1);
    @(posedge clk); #1 ready_man = 1'b1;
    wait_idle("stall_drain_timeout");
    chk("stall_req_count", 64'(req_cyc.size()), 2);

    // Random traffic, all acks within the window (15 = ack on the timeout cycle).
    rnd_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      n = (i % 5 == 0) ? TMO - 1 : int'($urandom_range(1, TMO - 1));
      push(rnd_f(), rnd_f(), n, t);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_ready = 1'b0;
    wait_idle("rnd1_drain_timeout");
    chk("rnd1_no_tmo_err", 64'(tmo_err), 0);

    // FU never acks: abort, drop, then next entry issues normally.
    req_cyc.delete();
    push(rnd_f(), rnd_f(), 0, t);
    push(rnd_f(), rnd_f(), 2, t);
    tv = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tmo_err) begin tv = cyc; break; end
    end
    wait_idle("tmo_drain_timeout");
    chk("tmo_req_count", 64'(req_cyc.size()), 2);
    if (req_cyc.size() > 1) begin
      chk("tmo_err_timing", 64'(tv), 64'(req_cyc[0] + TMO));
      chk("tmo_next_req", 64'(req_cyc[1]), 64'(req_cyc[0] + TMO + 1));
    end

    // Random traffic including dropped entries.
    rnd_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      n = int'($urandom_range(1, TMO + 2));
      if (n >= TMO) n = 0;
      push(rnd_f(), rnd_f(), n, t);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_ready = 1'b0;
    wait_idle("rnd2_drain_timeout");
    chk("rnd2_tmo_err_sticky", 64'(tmo_err), 1);

    // Spurious ack in IDLE, then reset mid-WAIT and a late ack.
    fu_auto = 1'b0;
    @(negedge clk) man_ack = 1'b1;
    @(negedge clk) man_ack = 1'b0;
    @(negedge clk);
    chk("spurious_out_valid", 64'(out_valid), 0);
    chk("spurious_busy", 64'(busy), 0);
    @(posedge clk); #1;
    push(rnd_f(), rnd_f(), 0, t);
    repeat (4) @(negedge clk);
    chk("midcall_busy", 64'(busy), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk) man_ack = 1'b1;
    @(negedge clk) man_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("late_ack");
    chk("late_ack_in_ready", 64'(in_ready), 1);
    fu_auto = 1'b1;

    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
